// File: rtl/fcw_arbiter_pkg.sv
// Shared state/pending codes and sizing helpers for the NCO frequency-control-word arbiter.
package fcw_arbiter_pkg;

    localparam int FCW_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_KEY  = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_SEQ  = 2'd1,
        PEND_KEY  = 2'd2
    } pending_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_SEQ  = 2'b01;
    localparam logic [1:0] GRANT_KEY  = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fcw_arbiter_load_counter.sv
// Loadable down-counter used for both key-note duration and inter-source gap timing.
module load_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority so a re-trigger on the final cycle restarts cleanly.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/fcw_arbiter.sv
// Shares one NCO frequency-control word between the sequencer stream and one-shot key notes,
// with an optional silent gap between different sources.
module fcw_arbiter
    import fcw_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_SECOND = 125_000_000,
    parameter int KEY_CYCLES        = CYCLES_PER_SECOND / 4,
    parameter int GAP_CYCLES        = CYCLES_PER_SECOND / 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FCW_W-1:0] seq_fcw,
    input  logic             seq_valid,
    input  logic [FCW_W-1:0] key_fcw,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [FCW_W-1:0] fcw,
    output logic [1:0]       grant,
    output logic [1:0]       arb_state
);

    localparam int CNT_W = $clog2(max_int(KEY_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] KEY_LOAD = CNT_W'(KEY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    arb_state_e       state_q, state_d;
    pending_e         pending_q, pending_d;
    logic [FCW_W-1:0] fcw_q, fcw_d;
    logic [FCW_W-1:0] key_fcw_q, key_fcw_d;
    logic [1:0]       grant_q, grant_d;
    logic             key_ready_q, key_ready_d;

    logic             key_acc;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign key_acc = key_valid & key_ready_q;

    load_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        key_fcw_d = key_fcw_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;

        case (state_q)
            ST_IDLE, ST_SEQ: begin
                if (key_acc) begin
                    key_fcw_d = key_fcw;
                    cnt_load  = 1'b1;
                    if (HAS_GAP) begin
                        state_d   = ST_GAP;
                        pending_d = PEND_KEY;
                        cnt_val   = GAP_LOAD;
                    end else begin
                        state_d = ST_KEY;
                        cnt_val = KEY_LOAD;
                    end
                end else if (state_q == ST_IDLE && seq_valid) begin
                    state_d = ST_SEQ;
                end else if (state_q == ST_SEQ && !seq_valid) begin
                    state_d = ST_IDLE;
                end
            end

            ST_KEY: begin
                cnt_dec = 1'b1;
                if (key_acc) begin
                    // Legato: a new note replaces the current one with no gap.
                    key_fcw_d = key_fcw;
                    cnt_load  = 1'b1;
                    cnt_val   = KEY_LOAD;
                end else if (cnt_zero) begin
                    if (seq_valid && HAS_GAP) begin
                        state_d   = ST_GAP;
                        pending_d = PEND_SEQ;
                        cnt_load  = 1'b1;
                        cnt_val   = GAP_LOAD;
                    end else if (seq_valid) begin
                        state_d = ST_SEQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                cnt_dec = 1'b1;
                // A key arriving while waiting to return to the sequencer takes the gap's slot.
                if (key_acc) begin
                    key_fcw_d = key_fcw;
                    pending_d = PEND_KEY;
                end
                if (cnt_zero) begin
                    if (pending_d == PEND_KEY) begin
                        state_d  = ST_KEY;
                        cnt_load = 1'b1;
                        cnt_val  = KEY_LOAD;
                    end else if (seq_valid) begin
                        state_d = ST_SEQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    pending_d = PEND_NONE;
                end
            end
        endcase

        // Outputs follow the next state so they are registered alongside it.
        case (state_d)
            ST_SEQ: begin
                fcw_d   = seq_fcw;
                grant_d = GRANT_SEQ;
            end
            ST_KEY: begin
                fcw_d   = key_fcw_d;
                grant_d = GRANT_KEY;
            end
            default: begin
                fcw_d   = '0;
                grant_d = GRANT_NONE;
            end
        endcase
        key_ready_d = !((state_d == ST_GAP) && (pending_d == PEND_KEY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= PEND_NONE;
            fcw_q       <= '0;
            grant_q     <= GRANT_NONE;
            key_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            fcw_q       <= fcw_d;
            grant_q     <= grant_d;
            key_ready_q <= key_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        key_fcw_q <= key_fcw_d;
    end

    assign fcw       = fcw_q;
    assign grant     = grant_q;
    assign key_ready = key_ready_q;
    assign arb_state = state_q;

endmodule
